// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs RV32I instruction fields into 32-bit instruction words. It is the
// reverse of the decode path and feeds the debug/boot injection port of the
// fetch mux. The LI pseudo-op is expanded into LUI+ADDI, or a single word
// when one instruction is enough.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that transfer. The output payload (out_instr/out_last) is held
// stable while out_valid && !out_ready.
//
// Optional feature: define INSTR_ENCODER_CHECK_EN to reject requests whose
// immediate does not fit its format, and requests with the reserved fmt=7.
// A rejected request is still consumed and err_imm pulses on the next cycle.
// Without the macro there are no checks: err_imm is tied to 0, immediate bits
// that do not fit are dropped, and fmt=7 is encoded as an I-type word.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_fmt                0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
//   req_opcode/funct3/funct7/rd/rs1/rs2/imm   instruction fields
//   out_valid/out_ready    output handshake
//   out_instr, out_last    encoded word; out_last marks the last word of a request
//   err_imm                one-cycle pulse when a request is rejected
//   count                  number of words emitted (wraps)
//   state_dbg              FSM state (0=IDLE, 1=EMIT2)
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_fmt,
    input  logic [6:0]         req_opcode,
    input  logic [2:0]         req_funct3,
    input  logic [6:0]         req_funct7,
    input  logic [4:0]         req_rd,
    input  logic [4:0]         req_rs1,
    input  logic [4:0]         req_rs2,
    input  logic [31:0]        req_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_last,
    output logic               err_imm,
    output logic [COUNT_W-1:0] count,
    output logic               state_dbg
);
    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;

    typedef enum logic {IDLE = 1'b0, EMIT2 = 1'b1} state_t;

    state_t      state, state_next;
    logic        load_ok, accept, reject, load_new, load_addi;
    logic [31:0] enc_word, addi_word;
    logic        enc_last, enc_two;
    logic        fits12, fits13, fits21;
    logic [19:0] li_hi;

    // An immediate fits in n signed bits when bits [31:n-1] are all equal.
    assign fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign fits13 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
    assign fits21 = (&req_imm[31:20]) | ~(|req_imm[31:20]);

    // LUI value is (imm + 0x800) >> 12. Adding 0x800 carries into bit 12
    // exactly when imm[11] is set, so only the top 20 bits need an adder.
    // This rounding pre-compensates for ADDI sign-extending its low 12 bits.
    assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};

`ifdef INSTR_ENCODER_CHECK_EN
    always_comb begin
        reject = 1'b0;
        case (req_fmt)
            FMT_I, FMT_S: reject = !fits12;
            FMT_B:        reject = !fits13 || req_imm[0];
            FMT_J:        reject = !fits21 || req_imm[0];
            FMT_U:        reject = |req_imm[11:0];
            3'd7:         reject = 1'b1;
            default:      reject = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_imm <= 1'b0;
        else       err_imm <= accept && reject;
    end
`else
    assign reject  = 1'b0;
    assign err_imm = 1'b0;
`endif

    // Encoder for the word produced when a request is accepted.
    always_comb begin
        enc_word = '0;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        case (req_fmt)
            FMT_R: enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
            FMT_S: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
            FMT_B: enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                               req_imm[4:1], req_imm[11], req_opcode};
            FMT_U: enc_word = {req_imm[31:12], req_rd, req_opcode};
            FMT_J: enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                               req_rd, req_opcode};
            FMT_LI: begin
                if (fits12) begin
                    enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
                end else begin
                    enc_word = {li_hi, req_rd, OP_LUI};
                    // A zero low part makes the ADDI a no-op, so the LUI stands alone.
                    enc_two  = |req_imm[11:0];
                    enc_last = ~enc_two;
                end
            end
            // FMT_I, and the reserved code when it is not rejected.
            default: enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        endcase
    end

    assign load_ok   = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;
    assign load_new  = accept && !reject;
    assign load_addi = (state == EMIT2) && load_ok;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_new && enc_two) state_next = EMIT2;
            EMIT2:   if (load_ok)             state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state == IDLE) && load_ok;
        state_dbg = (state == EMIT2);
    end

    // Output stage, pending ADDI of a two-word LI, and emitted-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_last  <= 1'b0;
            addi_word <= '0;
            count     <= '0;
        end else begin
            if (load_new) begin
                out_valid <= 1'b1;
                out_instr <= enc_word;
                out_last  <= enc_last;
            end else if (load_addi) begin
                out_valid <= 1'b1;
                out_instr <= addi_word;
                out_last  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_new && enc_two)
                addi_word <= {req_imm[11:0], req_rd, 3'b000, req_rd, OP_IMM};
            if (out_valid && out_ready)
                count <= count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder. Counter width is reduced so that the
// wrap of count is reached with a short stimulus.
module tb_instr_encoder;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [2:0]    req_fmt;
    logic [6:0]    req_opcode, req_funct7;
    logic [2:0]    req_funct3;
    logic [4:0]    req_rd, req_rs1, req_rs2;
    logic [31:0]   req_imm;
    logic          out_valid, out_ready, out_last, err_imm, state_dbg;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    logic [32:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_words  = 0;

    instr_encoder #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_opcode(req_opcode), .req_funct3(req_funct3),
        .req_funct7(req_funct7), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_last(out_last), .err_imm(err_imm), .count(count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_count();
        logic [CW-1:0] exp_cnt;
        exp_cnt = n_words[CW-1:0];
        check("count", {{(33-CW){1'b0}}, count}, {{(33-CW){1'b0}}, exp_cnt});
    endtask

    // ---------------- scoreboard ----------------
    // Output is sampled on the falling edge, half a cycle before the
    // rising edge that completes the transfer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $error("FAIL unexpected_word: observed 0x%0h expected none", out_instr);
            end else begin
                check("word", {out_last, out_instr}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic last, input logic [31:0] instr);
        exp_q.push_back({last, instr});
        n_words++;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int t = 0;
        while (!req_ready && t < 100) begin
            tick();
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            $error("FAIL send_timeout: req_ready observed 0 expected 1");
        end
        req_valid  = 1'b1;
        req_fmt    = fmt;
        req_opcode = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $error("FAIL drain_timeout: observed %0d words left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        req_fmt = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err_imm", err_imm, 0);
        check("rst_count", count, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        tick();

        // ADDI x1,x0,5 with one-cycle latency
        expect_word(1, 32'h00500093);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("latency_valid", out_valid, 1);
        check("latency_instr", out_instr, 32'h00500093);
        drain();
        check_count();

        // BEQ x1,x2,+8 and BNE x1,x2,-4
        expect_word(1, 32'h00208463);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word(1, 32'hFE209EE3);
        send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        drain();

`ifdef INSTR_ENCODER_CHECK_EN
        // Odd branch offset and reserved format are rejected
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        check("b_odd_err", err_imm, 1);
        check("b_odd_no_word", out_valid, 0);
        tick();
        check("b_odd_err_clear", err_imm, 0);
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("fmt7_err", err_imm, 1);
        check("fmt7_no_word", out_valid, 0);
        tick();
`else
        // Without checks, imm[0] is dropped and fmt=7 encodes as I
        expect_word(1, 32'h00208363);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        expect_word(1, 32'h00500093);
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();
        check("nochk_err_imm", err_imm, 0);
`endif
        check_count();

        // R, S, U, J formats
        expect_word(1, 32'h002081B3);
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word(1, 32'h402081B3);
        send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word(1, 32'h0020A623);
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd12);
        expect_word(1, 32'hFE20AE23);
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        expect_word(1, 32'hABCDE3B7);
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCDE000);
        expect_word(1, 32'h001000EF);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
        expect_word(1, 32'hFFFFF06F);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE);
        drain();
        check_count();

        // LI expansions
        expect_word(0, 32'h123452B7);
        expect_word(1, 32'h67828293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        check("li2_state_emit2", state_dbg, 1);
        check("li2_req_ready", req_ready, 0);
        drain();
        expect_word(0, 32'h123462B7);
        expect_word(1, 32'h80028293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345800);
        drain();
        expect_word(1, 32'h00001337);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'h00001000);
        check("li1_req_ready", req_ready, 1);
        check("li1_state_idle", state_dbg, 0);
        expect_word(1, 32'hFFF00293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
        expect_word(1, 32'h7FF00293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2047);
        expect_word(1, 32'h80000293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFF800);
        expect_word(0, 32'h000012B7);
        expect_word(1, 32'h80028293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048);
        drain();
        check_count();

        // Backpressure during a two-word LI
        out_ready = 1'b0;
        expect_word(0, 32'h123452B7);
        expect_word(1, 32'h67828293);
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_instr", out_instr, 32'h123452B7);
            check("bp_last", out_last, 0);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        drain();
        check_count();

        // Back-to-back R-type words, wrapping the counter
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                expect_word(1, 32'h002081B3);
                send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
            end else begin
                expect_word(1, 32'h402081B3);
                send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
            end
        end
        drain();
        check_count();

        // Reset while the LI is waiting in EMIT2
        out_ready = 1'b0;
        send(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        check("emit2_before_reset", state_dbg, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_state", state_dbg, 0);
        tick();
        reset = 1'b0;
        n_words = 0;
        out_ready = 1'b1;
        tick();
        expect_word(1, 32'h00500093);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();
        check_count();

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
